// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared multicycle MIPS control encodings (states, opcodes, mux selects)
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_INIT, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC, S_R_WB, S_ADDI_EX, S_ADDI_WB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle MIPS datapath
// Ports: Clk, Reset (sync, active-high), Opcode (IR[31:26], used in DECODE),
// MemReady (memory handshake); datapath strobes/selects out; Halt sticky on illegal opcode.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCwrite,
    output logic       PCwriteCOND,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       Halt
);

    state_t state, next;
    // Opcode is only valid in DECODE, so MEM_ADDR needs the lw/sw choice remembered.
    logic   is_lw;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_INIT;
            is_lw <= 1'b0;
        end else begin
            state <= next;
            if (state == S_DECODE) is_lw <= (Opcode == OP_LW);
        end
    end

    always_comb begin
        next        = state;
        PCwrite     = 1'b0;
        PCwriteCOND = 1'b0;
        PCSource    = PCSRC_ALU;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_ADD;
        Halt        = 1'b0;
        case (state)
            S_INIT: next = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCwrite = MemReady;
                next    = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
                next    = (Opcode == OP_LW || Opcode == OP_SW) ? S_MEM_ADDR :
                          (Opcode == OP_RTYPE) ? S_EXEC :
                          (Opcode == OP_ADDI)  ? S_ADDI_EX :
                          (Opcode == OP_BEQ)   ? S_BRANCH :
                          (Opcode == OP_J)     ? S_JUMP : S_HALT;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                next    = is_lw ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                next    = MemReady ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                next     = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                next     = MemReady ? S_FETCH : S_MEM_WR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                next    = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                next     = S_FETCH;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                next    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
                next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCwriteCOND = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                next        = S_FETCH;
            end
            S_JUMP: begin
                PCwrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                next     = S_FETCH;
            end
            S_HALT: Halt = 1'b1;
            default: next = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random + directed check of multicycle_control against a step-sequence model
module tb_multicycle_control;
    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] Opcode = 6'd0;
    logic       MemReady = 1'b0;
    logic       PCwrite, PCwriteCOND, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, Halt;
    logic [1:0] PCSource, ALUSrcB, ALUOp;

    multicycle_control dut (
        .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCwrite(PCwrite), .PCwriteCOND(PCwriteCOND), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Halt(Halt)
    );

    always #5 Clk = ~Clk;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, JMP = 6'b000010;

    // {Halt,PCwrite,PCwriteCOND,PCSource,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp}
    logic [16:0] dut_w;
    assign dut_w = {Halt, PCwrite, PCwriteCOND, PCSource, IorD, MemRead, MemWrite, IRWrite,
                    RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp};

    localparam logic [16:0] W_INIT  = 17'b0_0_0_00_0_0_0_0_0_0_0_0_00_00;
    localparam logic [16:0] W_F1    = 17'b0_1_0_00_0_1_0_1_0_0_0_0_01_00;
    localparam logic [16:0] W_F0    = 17'b0_0_0_00_0_1_0_0_0_0_0_0_01_00;
    localparam logic [16:0] W_DEC   = 17'b0_0_0_00_0_0_0_0_0_0_0_0_11_00;
    localparam logic [16:0] W_MADDR = 17'b0_0_0_00_0_0_0_0_0_0_0_1_10_00;
    localparam logic [16:0] W_MRD   = 17'b0_0_0_00_1_1_0_0_0_0_0_0_00_00;
    localparam logic [16:0] W_MWB   = 17'b0_0_0_00_0_0_0_0_0_1_1_0_00_00;
    localparam logic [16:0] W_MWR   = 17'b0_0_0_00_1_0_1_0_0_0_0_0_00_00;
    localparam logic [16:0] W_BR    = 17'b0_0_1_01_0_0_0_0_0_0_0_1_00_01;
    localparam logic [16:0] W_JMP   = 17'b0_1_0_10_0_0_0_0_0_0_0_0_00_00;
    localparam logic [16:0] W_HALT  = 17'b1_0_0_00_0_0_0_0_0_0_0_0_00_00;

    int cmp = 0;
    int mis = 0;

    // Model: an instruction is a sequence of steps; step 0 fetch, 1 decode, then op-specific.
    bit         mv = 1'b0, m_init = 1'b0, m_halt = 1'b0;
    int         m_step = 0;
    logic [5:0] m_op = 6'd0;

    function automatic int op_len(input logic [5:0] op);
        return op == LW ? 5 : (op == SW || op == RT || op == ADDI) ? 4 :
               (op == BEQ || op == JMP) ? 3 : 0;
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            mv = 1'b1; m_init = 1'b1; m_halt = 1'b0;
        end else if (mv && m_init) begin
            m_init = 1'b0; m_step = 0;
        end else if (mv && !m_halt) begin
            if (m_step == 0) begin
                if (MemReady) m_step = 1;
            end else if (m_step == 1) begin
                m_op = Opcode;
                if (op_len(Opcode) == 0) m_halt = 1'b1; else m_step = 2;
            end else if (!(m_step == 3 && (m_op == LW || m_op == SW) && !MemReady)) begin
                m_step = (m_step + 1 == op_len(m_op)) ? 0 : m_step + 1;
            end
        end
    end

    function automatic logic [16:0] expect_w(input logic rdy);
        logic h, pw, pc, iod, mr, mw, ir, rd, mt, rw, a;
        logic [1:0] ps, b, o;
        {h, pw, pc, iod, mr, mw, ir, rd, mt, rw, a, ps, b, o} = '0;
        if (m_halt) h = 1'b1;
        else if (!m_init) begin
            if (m_step == 0) begin mr = 1'b1; b = 2'b01; ir = rdy; pw = rdy; end
            else if (m_step == 1) b = 2'b11;
            else if (m_step == 2) begin
                if (m_op == LW || m_op == SW || m_op == ADDI) begin a = 1'b1; b = 2'b10; end
                if (m_op == RT) begin a = 1'b1; o = 2'b10; end
                if (m_op == BEQ) begin a = 1'b1; o = 2'b01; pc = 1'b1; ps = 2'b01; end
                if (m_op == JMP) begin pw = 1'b1; ps = 2'b10; end
            end else if (m_step == 3) begin
                if (m_op == LW) begin mr = 1'b1; iod = 1'b1; end
                if (m_op == SW) begin mw = 1'b1; iod = 1'b1; end
                if (m_op == RT) begin rw = 1'b1; rd = 1'b1; end
                if (m_op == ADDI) rw = 1'b1;
            end else begin
                rw = 1'b1; mt = 1'b1;
            end
        end
        return {h, pw, pc, ps, iod, mr, mw, ir, rd, mt, rw, a, b, o};
    endfunction

    always @(negedge Clk) begin
        if (mv) begin
            cmp++;
            if (dut_w !== expect_w(MemReady)) begin
                mis++;
                $display("FAIL model t=%0t got %b want %b", $time, dut_w, expect_w(MemReady));
            end
            cmp++;
            assert (!(PCwrite && PCwriteCOND) && !(MemRead && MemWrite)) else begin
                mis++;
                $display("FAIL excl t=%0t PCwrite=%b PCwriteCOND=%b MemRead=%b MemWrite=%b want no pair both 1",
                         $time, PCwrite, PCwriteCOND, MemRead, MemWrite);
            end
        end
    end

    task automatic drive(input logic r, input logic [5:0] op, input logic rdy);
        @(posedge Clk);
        #1;
        Reset = r; Opcode = op; MemReady = rdy;
    endtask

    task automatic dl(input string nm, input logic r, input logic [5:0] op, input logic rdy,
                      input logic [16:0] exp_w);
        drive(r, op, rdy);
        @(negedge Clk);
        cmp++;
        if (dut_w !== exp_w) begin
            mis++;
            $display("FAIL %s got %b want %b", nm, dut_w, exp_w);
        end
    endtask

    initial begin
        int hc;
        logic [5:0] ops [6];
        ops = '{LW, SW, RT, ADDI, BEQ, JMP};
        drive(1'b1, 6'd0, 1'b1);
        dl("init", 0, LW, 1, W_INIT);
        dl("fetch", 0, LW, 1, W_F1);
        dl("lw_decode", 0, LW, 1, W_DEC);
        dl("lw_addr", 0, 6'd0, 1, W_MADDR);
        dl("lw_rd", 0, 6'd0, 1, W_MRD);
        dl("lw_wb", 0, 6'd0, 1, W_MWB);
        dl("lw_refetch", 0, 6'd0, 1, W_F1);
        dl("sw_decode", 0, SW, 1, W_DEC);
        dl("sw_addr", 0, 6'd0, 1, W_MADDR);
        for (int i = 0; i < 3; i++) dl("sw_wait", 0, 6'd0, 0, W_MWR);
        dl("sw_done", 0, 6'd0, 1, W_MWR);
        dl("fetch_wait0", 0, 6'd0, 0, W_F0);
        dl("fetch_wait1", 0, 6'd0, 0, W_F0);
        dl("fetch_go", 0, 6'd0, 1, W_F1);
        dl("beq_decode", 0, BEQ, 1, W_DEC);
        dl("branch", 0, 6'd0, 1, W_BR);
        dl("fetch_j", 0, 6'd0, 1, W_F1);
        dl("j_decode", 0, JMP, 1, W_DEC);
        dl("jump", 0, 6'd0, 1, W_JMP);
        dl("fetch_ill", 0, 6'd0, 1, W_F1);
        dl("ill_decode", 0, 6'b111111, 1, W_DEC);
        for (int i = 0; i < 10; i++) dl("halt_hold", 0, $urandom_range(0, 63), 1, W_HALT);
        dl("halt_rst", 1, 6'd0, 1, W_HALT);
        dl("halt_init", 0, 6'd0, 1, W_INIT);
        dl("fetch_r", 0, 6'd0, 1, W_F1);
        dl("r_decode", 0, LW, 1, W_DEC);
        dl("r_addr", 0, 6'd0, 0, W_MADDR);
        dl("rd_rst", 1, 6'd0, 0, W_MRD);
        dl("rd_init", 0, 6'd0, 1, W_INIT);
        hc = 0;
        for (int i = 0; i < 4000; i++) begin
            hc = m_halt ? hc + 1 : 0;
            drive(($urandom_range(0, 99) < 2) || hc > 12,
                  ($urandom_range(0, 19) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 5)],
                  $urandom_range(0, 3) != 0);
        end
        @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule
